// File: rtl/fetch_unit.sv
// fetch_unit: multi-cycle instruction fetch with a PC register, one outstanding imem request,
// and a valid/ack handoff to decode; accepts taken-branch redirects in any state.
`default_nettype none

module fetch_unit #(
   parameter int              N        = 64,
   parameter logic [N-1:0]    RESET_PC = '0
) (
   input  logic          clk,
   input  logic          reset,
   output logic          imem_req,
   output logic [N-1:0]  imem_addr,
   input  logic          imem_rdy,
   input  logic [31:0]   imem_rdata,
   output logic          instr_valid,
   output logic [31:0]   instr,
   output logic [N-1:0]  instr_pc,
   input  logic          instr_ack,
   input  logic          br_valid,
   input  logic [N-1:0]  br_base,
   input  logic [N-1:0]  br_imm
);

   localparam logic [1:0] FETCH = 2'd0;
   localparam logic [1:0] HOLD  = 2'd1;
   localparam logic [1:0] DROP  = 2'd2;

   localparam logic [N-3:0] ONE_WORD = {{(N-3){1'b0}}, 1'b1};

   logic [1:0]   state;
   logic [N-1:0] pc;
   logic [N-1:0] redirect;
   logic [N-1:0] target;
   logic [N-1:0] pc_seq;

   // Arithmetic is done on word addresses so the low two bits stay zero by construction.
   assign target    = {br_base[N-1:2] + br_imm[N-3:0], 2'b00};
   assign pc_seq    = {instr_pc[N-1:2] + ONE_WORD, 2'b00};
   assign imem_addr = pc;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         redirect    <= '0;
         imem_req    <= 1'b0;
         instr_valid <= 1'b0;
         instr       <= '0;
         instr_pc    <= '0;
      end else begin
         case (state)
            FETCH: begin
               // The first cycle out of reset has no request issued yet, so a response is ignored.
               if (!imem_req) begin
                  imem_req <= 1'b1;
               end else if (imem_rdy && !br_valid) begin
                  instr       <= imem_rdata;
                  instr_pc    <= pc;
                  instr_valid <= 1'b1;
                  imem_req    <= 1'b0;
                  state       <= HOLD;
               end else if (imem_rdy) begin
                  pc <= target;
               end else if (br_valid) begin
                  redirect <= target;
                  state    <= DROP;
               end
            end
            DROP: begin
               if (br_valid) begin
                  redirect <= target;
               end
               if (imem_rdy) begin
                  pc    <= br_valid ? target : redirect;
                  state <= FETCH;
               end
            end
            HOLD: begin
               if (br_valid) begin
                  instr_valid <= 1'b0;
                  imem_req    <= 1'b1;
                  pc          <= target;
                  state       <= FETCH;
               end else if (instr_ack) begin
                  instr_valid <= 1'b0;
                  imem_req    <= 1'b1;
                  pc          <= pc_seq;
                  state       <= FETCH;
               end
            end
            default: begin
               instr_valid <= 1'b0;
               imem_req    <= 1'b0;
               state       <= FETCH;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a behavioural model.
`default_nettype none

module tb_fetch_unit;
   localparam int          N    = 64;
   localparam logic [N-1:0] RPC0 = 64'h0;
   localparam logic [N-1:0] RPC1 = 64'hFFFF_FFFF_FFFF_FFFC;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset = 1'b1, imem_rdy = 1'b0, instr_ack = 1'b0, br_valid = 1'b0;
   logic [31:0]   imem_rdata = '0;
   logic [N-1:0]  br_base = '0, br_imm = '0;
   wire           imem_req, instr_valid;
   wire [N-1:0]   imem_addr, instr_pc;
   wire [31:0]    instr;

   logic          b_reset = 1'b1, b_rdy = 1'b0, b_ack = 1'b0, b_br = 1'b0;
   logic [31:0]   b_rdata = '0;
   logic [N-1:0]  b_base = '0, b_imm = '0;
   wire           b_req, b_valid;
   wire [N-1:0]   b_addr, b_ipc;
   wire [31:0]    b_instr;

   fetch_unit #(.N(N), .RESET_PC(RPC0)) dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdy(imem_rdy), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
      .instr(instr), .instr_pc(instr_pc), .instr_ack(instr_ack),
      .br_valid(br_valid), .br_base(br_base), .br_imm(br_imm));

   fetch_unit #(.N(N), .RESET_PC(RPC1)) dut_hi (
      .clk(clk), .reset(b_reset), .imem_req(b_req), .imem_addr(b_addr),
      .imem_rdy(b_rdy), .imem_rdata(b_rdata), .instr_valid(b_valid),
      .instr(b_instr), .instr_pc(b_ipc), .instr_ack(b_ack),
      .br_valid(b_br), .br_base(b_base), .br_imm(b_imm));

   int n_chk = 0;
   int n_fail = 0;

   // Reference model: what the fetch stage is doing, in terms of the stage's rules
   logic [N-1:0] m_pc, m_redir, m_ipc;
   logic [31:0]  m_instr;
   bit m_req, m_valid, m_drop, m_live, m_rst;
   logic [N-1:0] pcq[$];

   function automatic logic [31:0] mem_word(logic [N-1:0] a);
      return (a[33:2] * 32'h9E37_79B1) ^ 32'h5A5A_0F0F ^ a[63:32];
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      logic [N-1:0] tgt;
      tgt   = br_base + (br_imm << 2);
      m_rst = 1'b0;
      if (reset) begin
         m_pc = RPC0; m_redir = '0; m_req = 0; m_valid = 0; m_drop = 0;
         m_instr = '0; m_ipc = '0; m_live = 1; m_rst = 1;
      end else if (!m_live) begin
         m_live = 0;
      end else if (m_valid) begin
         if (br_valid) begin
            m_valid = 0; m_pc = tgt; m_req = 1;
         end else if (instr_ack) begin
            m_valid = 0; m_pc = m_ipc + 4; m_req = 1;
         end
      end else if (!m_req) begin
         m_req = 1;
      end else if (m_drop) begin
         if (br_valid) m_redir = tgt;
         if (imem_rdy) begin
            m_pc = m_redir; m_drop = 0;
         end
      end else if (imem_rdy && !br_valid) begin
         m_instr = mem_word(m_pc); m_ipc = m_pc; m_valid = 1; m_req = 0;
      end else if (imem_rdy) begin
         m_pc = tgt;
      end else if (br_valid) begin
         m_redir = tgt; m_drop = 1;
      end
   endtask

   task automatic check_outputs();
      chk("imem_req", imem_req, m_req);
      chk("imem_addr", imem_addr, m_pc);
      chk("addr_align", imem_addr[1:0], 2'b00);
      chk("instr_valid", instr_valid, m_valid);
      if (m_valid || m_rst) begin
         chk("instr", instr, m_instr);
         chk("instr_pc", instr_pc, m_ipc);
      end
   endtask

   task automatic cyc(bit rdy, bit ack, bit br, logic [N-1:0] base, logic [N-1:0] imm);
      imem_rdy   = rdy;
      imem_rdata = rdy ? mem_word(m_pc) : $urandom;
      instr_ack  = ack;
      br_valid   = br;
      br_base    = base;
      br_imm     = imm;
      @(posedge clk);
      model_edge();
      #1;
      if (m_live) check_outputs();
   endtask

   task automatic run_auto(int cycles, int lmin, int lmax, int amin, int amax, int brpct, bit log_pc);
      int wcnt = 0, hcnt = 0, lat, ackd, s;
      bit r, a, b, was_req, was_valid;
      lat  = $urandom_range(lmax, lmin);
      ackd = $urandom_range(amax, amin);
      for (int i = 0; i < cycles; i++) begin
         r = m_req && (wcnt >= lat);
         a = m_valid && (hcnt >= ackd);
         b = (m_req || m_valid) && ($urandom_range(99) < brpct);
         s = int'($urandom_range(127)) - 64;
         was_req = m_req;
         was_valid = m_valid;
         cyc(r, a, b, {$urandom, $urandom} & ~64'h3, {{32{s[31]}}, s});
         if (r) begin
            wcnt = 0; lat = $urandom_range(lmax, lmin);
         end else if (was_req) begin
            wcnt++;
         end
         if (!m_valid) begin
            hcnt = 0;
            if (was_valid) ackd = $urandom_range(amax, amin);
         end else if (was_valid) begin
            hcnt++;
         end
         if (log_pc && m_valid && !was_valid) pcq.push_back(instr_pc);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      assert (RPC1[1:0] == 2'b00) else $fatal(1, "RESET_PC misaligned");

      // T1: reset held three cycles, outputs zero throughout
      reset = 1'b1;
      repeat (3) cyc(1, 1, 0, '0, '0);
      chk("t1_req_in_reset", imem_req, 1'b0);
      reset = 1'b0;
      cyc(0, 0, 0, '0, '0);
      chk("t1_req_after", imem_req, 1'b1);
      chk("t1_addr_after", imem_addr, 64'h0);

      // T2: zero-latency memory, immediate ack
      run_auto(9, 0, 0, 0, 0, 0, 1);
      chk("t2_count", (pcq.size() >= 4), 1'b1);
      if (pcq.size() >= 4) begin
         for (int i = 0; i < 4; i++) chk("t2_pc_seq", pcq[i], 64'(4 * i));
      end

      // T3: latency 3, ack after 2 held cycles
      run_auto(30, 3, 3, 2, 2, 0, 0);

      // T4: redirect in HOLD beats a simultaneous ack
      for (int i = 0; i < 10 && !m_valid; i++) cyc(m_req, 0, 0, '0, '0);
      chk("t4_in_hold", instr_valid, 1'b1);
      cyc(0, 0, 1, 64'h40, '0);
      cyc(1, 0, 0, '0, '0);
      chk("t4_pc40", instr_pc, 64'h40);
      cyc(0, 1, 1, 64'h40, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("t4_addr", imem_addr, 64'h30);
      chk("t4_valid", instr_valid, 1'b0);

      // T5: redirect while waiting, overwritten in DROP, response discarded
      cyc(0, 0, 1, 64'h100, 64'd2);
      chk("t5_addr_stable", imem_addr, 64'h30);
      cyc(0, 0, 1, 64'h100, 64'd8);
      cyc(1, 0, 0, '0, '0);
      chk("t5_dropped", instr_valid, 1'b0);
      chk("t5_addr", imem_addr, 64'h120);
      cyc(1, 0, 0, '0, '0);
      chk("t5_instr_pc", instr_pc, 64'h120);

      // Randomized traffic with redirects, then a reset mid-transaction
      run_auto(300, 0, 3, 0, 2, 12, 0);
      reset = 1'b1;
      cyc(1, 0, 0, '0, '0);
      reset = 1'b0;
      cyc(1, 0, 0, '0, '0);
      chk("rst_mid_valid", instr_valid, 1'b0);
      run_auto(200, 0, 2, 0, 3, 20, 0);

      // T6: top-of-memory reset PC wraps to 0; reset with a pending response
      b_reset = 1'b1;
      @(posedge clk); #1;
      chk("t6_req_rst", b_req, 1'b0);
      chk("t6_valid_rst", b_valid, 1'b0);
      b_reset = 1'b0;
      @(posedge clk); #1;
      chk("t6_req", b_req, 1'b1);
      chk("t6_addr_rpc", b_addr, RPC1);
      b_rdy = 1'b1; b_rdata = 32'h1234_5678;
      @(posedge clk); #1;
      b_rdy = 1'b0;
      chk("t6_valid", b_valid, 1'b1);
      chk("t6_instr", b_instr, 32'h1234_5678);
      chk("t6_ipc", b_ipc, RPC1);
      b_ack = 1'b1;
      @(posedge clk); #1;
      b_ack = 1'b0;
      chk("t6_wrap_addr", b_addr, 64'h0);
      chk("t6_wrap_req", b_req, 1'b1);
      @(posedge clk); #1;
      b_reset = 1'b1;
      @(posedge clk); #1;
      chk("t6_rst2_req", b_req, 1'b0);
      chk("t6_rst2_addr", b_addr, RPC1);
      b_reset = 1'b0; b_rdy = 1'b1;
      @(posedge clk); #1;
      b_rdy = 1'b0;
      chk("t6_late_rdy_valid", b_valid, 1'b0);
      chk("t6_late_rdy_req", b_req, 1'b1);
      @(posedge clk); #1;
      chk("t6_late_rdy_valid2", b_valid, 1'b0);
      chk("t6_late_rdy_addr", b_addr, RPC1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
